// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester lanes and UART TX handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;

    // Environment side: requesters plus the UART serializer.
    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output tx_busy,
        input  req_ready,
        input  grant,
        input  tx_start,
        input  tx_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  tx_busy,
        output req_ready,
        output grant,
        output tx_start,
        output tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART transmitter
// Grants whole packets, issues one tx_start per byte, aborts on a stalled requester or UART.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    uart_tx_arbiter_if.slave           bus,
    output logic                       err_timeout,
    output logic [$clog2(NUM_REQ)-1:0] err_id,
    output logic                       arb_busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic          pick_found;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          cnt_hit;
    logic          cnt_en;
    logic          last_q;
    logic [7:0]    tx_data_q;
    logic [7:0]    own_data;
    logic          own_valid;
    logic          own_last;
    logic          grab;
    logic          accept;
    logic          abort;
    logic          pkt_done;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IW'(sum);
    endfunction

    // First requesting lane at or after ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(ptr, k);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        own_data  = '0;
        own_valid = 1'b0;
        own_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) begin
                own_data  = bus.req_data[8*i +: 8];
                own_valid = bus.req_valid[i];
                own_last  = bus.req_last[i];
            end
        end
    end

    // Saturating counter; the abort fires on the cycle it would reach its last value.
    assign cnt_inc = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;
    assign cnt_hit = (cnt_inc == CNT_LAST);

    always_comb begin
        state_next = state;
        grab       = 1'b0;
        accept     = 1'b0;
        abort      = 1'b0;
        pkt_done   = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    grab       = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (own_valid) begin
                    accept     = 1'b1;
                    state_next = S_START;
                end else if (cnt_hit) begin
                    abort      = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_START: begin
                state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_next = S_WAIT_DONE;
                end else if (cnt_hit) begin
                    abort      = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        pkt_done   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Grant and strobes decode straight from state so reset clears them immediately.
    always_comb begin
        bus.grant = '0;
        if (state != S_IDLE) bus.grant[owner] = 1'b1;
        bus.req_ready = (state == S_FETCH) ? bus.grant : '0;
    end

    assign bus.tx_start = (state == S_START);
    assign bus.tx_data  = tx_data_q;
    assign arb_busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            last_q      <= 1'b0;
            tx_data_q   <= '0;
            err_timeout <= 1'b0;
            err_id      <= '0;
        end else begin
            err_timeout <= abort;
            cnt         <= cnt_en ? cnt_inc : '0;
            if (grab) owner <= pick_idx;
            if (accept) begin
                tx_data_q <= own_data;
                last_q    <= own_last;
            end
            if (abort) err_id <= owner;
            if (abort || pkt_done) ptr <= wrap_add(owner, 1);
        end
    end
endmodule
